wb_arb3: RTL and testbench

WB_ARB3 -- requirements
Module: wb_arb3

---
 rtl/wb_arb3.sv | 179 +++++++++++++++++
 tb/tb_wb_arb3.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb3.sv
// Three-master Wishbone arbiter: round-robin ownership, stall timeout abort, 2-flop reset release.
// Define WB_ARB3_DBG_PRIO_EN to give master 2 (dbg) absolute priority at arbitration time.
module wb_arb3 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  // masters, packed by index: 0 = or1k_i, 1 = or1k_d, 2 = dbg
  input  logic [3*AW-1:0]   m_adr_i,
  input  logic [3*DW-1:0]   m_dat_i,
  input  logic [11:0]       m_sel_i,
  input  logic [8:0]        m_cti_i,
  input  logic [5:0]        m_bte_i,
  input  logic [2:0]        m_we_i,
  input  logic [2:0]        m_cyc_i,
  input  logic [2:0]        m_stb_i,
  output logic [DW-1:0]     m_dat_o,
  output logic [2:0]        m_ack_o,
  output logic [2:0]        m_err_o,
  output logic [2:0]        m_rty_o,
  // slave
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [2:0]        grant_o
);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_pulse_q, err_pulse_d;

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  logic [1:0]  winner;
  logic        win_updates_last;
  logic        slave_resp;

  // Assertion is asynchronous; release is retimed so no flop sees reset drop near an edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (req[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef WB_ARB3_DBG_PRIO_EN
  assign winner           = m_cyc_i[2] ? 2'd2 : rr_pick({1'b0, m_cyc_i[1:0]}, last_q);
  assign win_updates_last = !m_cyc_i[2];
`else
  assign winner           = rr_pick(m_cyc_i, last_q);
  assign win_updates_last = 1'b1;
`endif

  assign slave_resp = s_ack_i | s_err_i | s_rty_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      last_q      <= 2'd2;
      cnt_q       <= 16'd0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    err_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (|m_cyc_i) begin
          state_d = OWN;
          owner_d = winner;
          if (win_updates_last) last_d = winner;
        end
      end
      OWN: begin
        if (!m_cyc_i[owner_q]) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (slave_resp) begin
          cnt_d = 16'd0;
        end else if (cnt_q == 16'(TIMEOUT)) begin
          state_d     = ABORT;
          cnt_d       = 16'd0;
          err_pulse_d = 1'b1;
        end else if (m_stb_i[owner_q]) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ABORT: begin
        cnt_d = 16'd0;
        if (!m_cyc_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_dat_o = s_dat_i;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = 3'b000;
    m_err_o = 3'b000;
    m_rty_o = 3'b000;
    grant_o = 3'b000;
    case (state_q)
      OWN: begin
        s_adr_o          = m_adr_i[int'(owner_q)*AW +: AW];
        s_dat_o          = m_dat_i[int'(owner_q)*DW +: DW];
        s_sel_o          = m_sel_i[int'(owner_q)*4 +: 4];
        s_cti_o          = m_cti_i[int'(owner_q)*3 +: 3];
        s_bte_o          = m_bte_i[int'(owner_q)*2 +: 2];
        s_we_o           = m_we_i[owner_q];
        s_cyc_o          = m_cyc_i[owner_q];
        s_stb_o          = m_stb_i[owner_q];
        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = s_err_i;
        m_rty_o[owner_q] = s_rty_i;
        grant_o[owner_q] = 1'b1;
      end
      ABORT: begin
        // Slave is cut off here; a late ack is dropped and only the abort error reaches the owner.
        m_err_o[owner_q] = err_pulse_q;
        grant_o[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arb3.sv
// Self-checking bench for wb_arb3 (TIMEOUT=4): table-driven arbitration/routing plus
// hand-written timeout, late-ack, round-robin order and reset-mid-burst sequences.
module tb_wb_arb3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3*AW-1:0] m_adr_i;
  logic [3*DW-1:0] m_dat_i;
  logic [11:0]     m_sel_i;
  logic [8:0]      m_cti_i;
  logic [5:0]      m_bte_i;
  logic [2:0]      m_we_i, m_cyc_i, m_stb_i;
  logic [DW-1:0]   m_dat_o;
  logic [2:0]      m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [3:0]      s_sel_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_we_o, s_cyc_o, s_stb_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i, s_rty_i;
  logic [2:0]      grant_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arb3 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_bte_i(m_bte_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [2:0] g);
    onehot_idx = g[0] ? 0 : (g[1] ? 1 : (g[2] ? 2 : -1));
  endfunction

  // Per-master field values the bench drives; the slave side must mirror the owner's.
  function automatic logic [31:0] adr_of(input int i);
    adr_of = 32'hA000_0000 + 32'(i);
  endfunction
  function automatic logic [3:0] sel_of(input int i);
    sel_of = (i == 0) ? 4'hF : ((i == 1) ? 4'h3 : 4'hC);
  endfunction
  function automatic logic we_of(input int i);
    we_of = (i != 1);
  endfunction

  typedef struct {
    logic [2:0] req;
    int         idx;   // expected winner
    int         resp;  // 0 ack, 1 err, 2 rty
  } vec_t;

  vec_t vecs[8];
  int   exp_order[4];
  int   order[4];
  int   drop[3];
  int   n_got, idle_run;
  logic [2:0] prev_g, exp_g;

  initial begin
    // Round-robin walk from reset (last = 2, so the first search begins at 0).
    vecs[0] = '{3'b111, 0, 0};
    vecs[1] = '{3'b111, 1, 1};
    vecs[2] = '{3'b101, 2, 2};
    vecs[3] = '{3'b011, 0, 0};
    vecs[4] = '{3'b100, 2, 1};
    vecs[5] = '{3'b010, 1, 2};
    vecs[6] = '{3'b101, 2, 0};
    vecs[7] = '{3'b110, 1, 1};
`ifdef WB_ARB3_DBG_PRIO_EN
    exp_order = '{2, 0, 2, 1};
`else
    exp_order = '{0, 1, 2, 0};
`endif

    rst_n   = 1'b0;
    m_adr_i = {adr_of(2), adr_of(1), adr_of(0)};
    m_dat_i = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    m_sel_i = {sel_of(2), sel_of(1), sel_of(0)};
    m_we_i  = {we_of(2), we_of(1), we_of(0)};
    m_cti_i = '0;
    m_bte_i = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_dat_i = 32'h5A5A_1234;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;

    tick(); tick();
    check("reset grant", grant_o, 3'b000);
    check("reset s_cyc", s_cyc_o, 1'b0);
    check("reset s_stb", s_stb_o, 1'b0);
    check("reset s_adr", s_adr_o, 32'h0);
    check("reset m_ack", m_ack_o, 3'b000);
    check("reset m_err", m_err_o, 3'b000);
    check("m_dat broadcast", m_dat_o, 32'h5A5A_1234);
    @(posedge clk); #2 rst_n = 1'b1;
    tick(); tick(); tick();

    for (int v = 0; v < 8; v++) begin
      m_cyc_i = vecs[v].req;
      m_stb_i = vecs[v].req;
      tick();
      exp_g = 3'b001 << vecs[v].idx;
      check($sformatf("vec%0d grant", v), grant_o, exp_g);
      check($sformatf("vec%0d s_cyc", v), s_cyc_o, 1'b1);
      check($sformatf("vec%0d s_adr", v), s_adr_o, adr_of(vecs[v].idx));
      check($sformatf("vec%0d s_sel", v), s_sel_o, sel_of(vecs[v].idx));
      check($sformatf("vec%0d s_we", v), s_we_o, we_of(vecs[v].idx));
      s_ack_i = (vecs[v].resp == 0);
      s_err_i = (vecs[v].resp == 1);
      s_rty_i = (vecs[v].resp == 2);
      #1;
      check($sformatf("vec%0d m_ack", v), m_ack_o, (vecs[v].resp == 0) ? exp_g : 3'b000);
      check($sformatf("vec%0d m_err", v), m_err_o, (vecs[v].resp == 1) ? exp_g : 3'b000);
      check($sformatf("vec%0d m_rty", v), m_rty_o, (vecs[v].resp == 2) ? exp_g : 3'b000);
      tick();
      {s_ack_i, s_err_i, s_rty_i} = 3'b000;
      m_cyc_i = '0;
      m_stb_i = '0;
      tick();
      check($sformatf("vec%0d idle grant", v), grant_o, 3'b000);
      check($sformatf("vec%0d idle s_cyc", v), s_cyc_o, 1'b0);
      check($sformatf("vec%0d idle s_adr", v), s_adr_o, 32'h0);
    end

    // Single requester, slave acks on the second OWN cycle.
    m_cyc_i = 3'b010; m_stb_i = 3'b010;
    tick();
    check("solo grant", grant_o, 3'b010);
    tick();
    check("solo wait ack", m_ack_o, 3'b000);
    s_ack_i = 1'b1; #1;
    check("solo ack", m_ack_o, 3'b010);
    check("solo ack m0", m_ack_o[0], 1'b0);
    tick();
    s_ack_i = 1'b0; #1;
    check("solo ack one cycle", m_ack_o, 3'b000);
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Stalled slave: abort error exactly five cycles after s_stb rises.
    m_cyc_i = 3'b001; m_stb_i = 3'b001;
    tick();
    check("to s_stb rises", s_stb_o, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("to no err t%0d", k), m_err_o, 3'b000);
      tick();
    end
    check("to err pulse", m_err_o, 3'b001);
    check("to abort s_cyc", s_cyc_o, 1'b0);
    check("to abort grant", grant_o, 3'b001);
    s_ack_i = 1'b1; #1;
    check("to late ack dropped", m_ack_o, 3'b000);
    tick();
    s_ack_i = 1'b0; #1;
    check("to err once", m_err_o, 3'b000);
    check("to grant held", grant_o, 3'b001);
    m_cyc_i = '0; m_stb_i = '0;
    tick();
    check("to grant released", grant_o, 3'b000);
    tick();

    // Ack lands on the cycle the stall counter reaches TIMEOUT: ack wins.
    m_cyc_i = 3'b010; m_stb_i = 3'b010;
    tick();
    tick(); tick(); tick(); tick();
    s_ack_i = 1'b1; #1;
    check("race ack", m_ack_o, 3'b010);
    check("race no err", m_err_o, 3'b000);
    tick();
    s_ack_i = 1'b0; #1;
    check("race still own", s_cyc_o, 1'b1);
    check("race grant", grant_o, 3'b010);
    check("race no err after", m_err_o, 3'b000);
    tick();
    check("race no err later", m_err_o, 3'b000);
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Fresh reset, then all masters re-requesting: grant order and dead cycle.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    drop = '{0, 0, 0};
    n_got = 0; idle_run = 0; prev_g = 3'b000;
    for (int c = 0; c < 60 && n_got < 4; c++) begin
      s_ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_cyc_i[i] = (drop[i] == 0);
        if (drop[i] > 0) drop[i]--;
      end
      m_stb_i = m_cyc_i;
      #1;
      s_ack_i = s_stb_o;
      #1;
      if (grant_o != 3'b000 && prev_g == 3'b000) begin
        if (n_got > 0) check($sformatf("rr gap %0d", n_got), 64'(idle_run), 64'd1);
        order[n_got] = onehot_idx(grant_o);
        n_got++;
      end
      idle_run = (grant_o == 3'b000) ? idle_run + 1 : 0;
      prev_g = grant_o;
      for (int i = 0; i < 3; i++) if (m_ack_o[i]) drop[i] = 2;
      tick();
    end
    s_ack_i = 1'b0;
    check("rr grants seen", 64'(n_got), 64'd4);
    for (int k = 0; k < 4 && k < n_got; k++)
      check($sformatf("rr order %0d", k), 64'(order[k]), 64'(exp_order[k]));
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Reset asserted in the middle of an incrementing burst.
    m_cti_i = {3'b010, 3'b010, 3'b010};
    m_cyc_i = 3'b111; m_stb_i = 3'b111;
    tick();
    check("burst owned", s_cyc_o, 1'b1);
    check("burst cti", s_cti_o, 3'b010);
    s_ack_i = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst async s_cyc", s_cyc_o, 1'b0);
    check("rst async grant", grant_o, 3'b000);
    check("rst no err", m_err_o, 3'b000);
    check("rst no ack", m_ack_o, 3'b000);
    s_ack_i = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("rst sync edge1", grant_o, 3'b000);
    tick();
    check("rst sync edge2", grant_o, 3'b000);
    tick();
    check("rst first grant", grant_o, 3'b001);
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
